bus_region_ctrl: RTL and testbench
==================================

# bus_region_ctrl

Parametrised bus-cycle controller for the 8088 minimum-mode bus. It replaces the free-standing ALE latch and the hand-written per-device chip-select equations. It registers the multiplexed address on ALE and decodes it against NUM_REGIONS programmable memory/IO windows, giving one-hot chip selects. It also generates per-region wait states on READY and flags accesses that hit no region.

## Interface
Parameters:
- NUM_REGIONS, 4: number of decode windows (1..16).
- ADDR_WIDTH, 20: width of the bus address.
- BASE_ADDRS, {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000}: packed, ADDR_WIDTH bits per region; region 0 is in the LSBs.
- ADDR_MASKS, {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000}: packed; a region hits when (addr & mask) == base.
- REGION_IS_IO, 4'b1100: bit r set means region r matches only when IOM=1; bit r clear means it matches only when IOM=0.
- WAIT_STATES, {4'd5, 4'd2, 4'd0, 4'd0}: packed, 4 bits per region; number of READY-low cycles (0..15).

Ports:
- CLK  in  1  bus clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ALE  in  1  address latch enable from the CPU.
- IOM  in  1  1 = IO cycle, 0 = memory cycle.
- RD  in  1  active-low read strobe.
- WR  in  1  active-low write strobe.
- ADDR_IN  in  ADDR_WIDTH  {A, AD} from the CPU.
- ADDR  out  ADDR_WIDTH  registered bus address.
- CS  out  NUM_REGIONS  one-hot, active-high chip selects.
- READY  out  1  to the CPU READY input.
- BUS_ERR  out  1  one-cycle pulse: a strobe was issued with no region selected.

## Operation
- Reset values: ADDR=0, CS=0, READY=1, BUS_ERR=0, FSM in IDLE, wait counter=0.
- Latch: on a rising edge with ALE=1, the block registers ADDR<=ADDR_IN and registers IOM. It also registers the decode result:
  - CS bit r is set for the lowest-index region with a type match and an address match.
  - All other CS bits are cleared, so CS is always one-hot or zero.
  - Overlapping windows resolve to the lowest index.
- CS and ADDR hold until the next ALE or RESET. They do not clear at strobe end.
- FSM states:
  - IDLE -> ADDR on ALE=1.
  - ADDR -> WAIT when (RD=0 or WR=0), CS≠0 and the selected WAIT_STATES≠0. The counter loads WAIT_STATES[sel]-1 and READY is driven to 0.
  - ADDR -> DONE when a strobe is active and (CS=0 or the selected WAIT_STATES=0). READY stays 1. If CS=0, BUS_ERR=1 for exactly that cycle.
  - WAIT: while the counter is nonzero, decrement it and keep READY=0. When the counter is 0, set READY=1 and go to DONE.
  - DONE -> IDLE when RD=1 and WR=1.
  - ALE=1 in any state has priority: it re-latches, goes to ADDR, forces READY=1 and abandons the count.
- RD=0 and WR=0 together are treated as one strobe; there is no error.
- A strobe in IDLE (no preceding ALE) is ignored: no READY change and no BUS_ERR.
- RESET in any state returns all outputs to their reset values on the next edge. RESET has priority over ALE.

## Timing
- ADDR and CS are valid from the edge that samples ALE=1. There is 1 cycle of latency from ALE.
- For WAIT_STATES=N>0, READY goes low at the edge that first samples a strobe low. It stays low for exactly N rising edges and returns high at the N-th edge after that.
- With WAIT_STATES=0, READY never drops.
- BUS_ERR asserts at the edge that first samples the strobe. It is high for 1 cycle and does not re-pulse while the strobe is held.
- Decode uses only registered values. CS has no combinational path from ADDR_IN.

## Test plan
- Reset, then memory read at 0x12345 (IOM=0): CS=4'b0001, ADDR=0x12345, READY stays 1, BUS_ERR=0.
- Memory write at 0x9ABCD: CS=4'b0010, READY stays 1. Then a new ALE with 0x00010: CS switches to 4'b0001 on the next edge.
- IO read at port 0xFF07: CS=4'b0100, READY low for exactly 2 cycles after RD sampled low, then high. IO write at 0x1DFF: CS=4'b1000, READY low for 5 cycles.
- IO read at port 0x3000 (no match): CS=0, BUS_ERR high for 1 cycle, READY stays 1, FSM returns to IDLE after RD rises.
- IO read at 0x1C00, RESET asserted on the 3rd READY-low cycle: the next edge gives READY=1, CS=0, ADDR=0. A following ALE-driven cycle decodes normally.
- IO read at 0x1C00, ALE asserted mid-wait with memory address 0x00000: READY returns to 1 and CS=4'b0001 on that edge.

Source files
------------

// File: rtl/bus_region_ctrl.sv
// 8088 minimum-mode bus-cycle controller: ALE address latch,
// windowed chip-select decode, per-region wait states and bus-error flag.
module bus_region_ctrl #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_WIDTH  = 20,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] BASE_ADDRS =
    {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] ADDR_MASKS =
    {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
  parameter logic [NUM_REGIONS-1:0] REGION_IS_IO = 4'b1100,
  parameter logic [NUM_REGIONS*4-1:0] WAIT_STATES =
    {4'd5, 4'd2, 4'd0, 4'd0}
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ALE,
  input  logic                   IOM,
  input  logic                   RD,
  input  logic                   WR,
  input  logic [ADDR_WIDTH-1:0]  ADDR_IN,
  output logic [ADDR_WIDTH-1:0]  ADDR,
  output logic [NUM_REGIONS-1:0] CS,
  output logic                   READY,
  output logic                   BUS_ERR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]             r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [NUM_REGIONS-1:0] r_cs;
  logic [3:0]             r_cnt;
  logic                   r_ready;
  logic                   r_err;

  logic [NUM_REGIONS-1:0] w_dec;
  logic                   w_found;
  logic [3:0]             w_ws;
  logic                   w_strobe;

  assign w_strobe = ~RD | ~WR;

  // Lowest-index matching window wins, so CS stays one-hot or zero.
  always_comb begin
    w_dec   = '0;
    w_found = 1'b0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (!w_found
          && (REGION_IS_IO[r] == IOM)
          && ((ADDR_IN & ADDR_MASKS[r*ADDR_WIDTH +: ADDR_WIDTH])
              == BASE_ADDRS[r*ADDR_WIDTH +: ADDR_WIDTH])) begin
        w_dec[r] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_ws = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (r_cs[r]) w_ws = w_ws | WAIT_STATES[r*4 +: 4];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cs    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else if (ALE) begin
      r_state <= S_ADDR;
      r_addr  <= ADDR_IN;
      r_cs    <= w_dec;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_IDLE;
        S_ADDR: begin
          if (w_strobe) begin
            if ((r_cs != '0) && (w_ws != 4'd0)) begin
              r_state <= S_WAIT;
              r_cnt   <= w_ws - 4'd1;
              r_ready <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_err   <= (r_cs == '0);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!w_strobe) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ADDR    = r_addr;
  assign CS      = r_cs;
  assign READY   = r_ready;
  assign BUS_ERR = r_err;

endmodule

// File: tb/tb_bus_region_ctrl.sv
// Bench for bus_region_ctrl: per-cycle expectations queued
// when stimulus is driven, popped and compared after the edge.
module tb_bus_region_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, ALE, IOM, RD, WR;
  logic [19:0] ADDR_IN;
  logic [19:0] ADDR;
  logic [3:0]  CS;
  logic        READY, BUS_ERR;

  typedef struct packed {
    logic [19:0] addr;
    logic [3:0]  cs;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int stepn    = 0;

  bus_region_ctrl dut (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM),
    .RD(RD), .WR(WR), .ADDR_IN(ADDR_IN),
    .ADDR(ADDR), .CS(CS), .READY(READY), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step %0d got %h want %h",
               tag, stepn, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ale,
                      input bit iom, input bit rd,
                      input bit wr, input logic [19:0] a,
                      input logic [19:0] ea,
                      input logic [3:0] ecs,
                      input bit erdy, input bit eerr);
    exp_t e;
    RESET = rst; ALE = ale; IOM = iom;
    RD = rd; WR = wr; ADDR_IN = a;
    exp_q.push_back('{ea, ecs, erdy, eerr});
    @(posedge CLK);
    #1;
    stepn++;
    e = exp_q.pop_front();
    chk("addr",  32'(ADDR),    32'(e.addr));
    chk("cs",    32'(CS),      32'(e.cs));
    chk("ready", 32'(READY),   32'(e.rdy));
    chk("berr",  32'(BUS_ERR), 32'(e.err));
  endtask

  initial begin
    RESET = 1; ALE = 0; IOM = 0; RD = 1; WR = 1; ADDR_IN = '0;
    //   rst ale iom rd wr addr_in    exp_addr   cs   rdy err
    step(1, 0, 0, 1, 1, 20'h00000, 20'h00000, 4'h0, 1, 0);
    step(1, 0, 0, 1, 1, 20'h00000, 20'h00000, 4'h0, 1, 0);
    // memory read, region 0, no waits
    step(0, 1, 0, 1, 1, 20'h12345, 20'h12345, 4'h1, 1, 0);
    step(0, 0, 0, 0, 1, 20'h00000, 20'h12345, 4'h1, 1, 0);
    step(0, 0, 0, 0, 1, 20'h00000, 20'h12345, 4'h1, 1, 0);
    step(0, 0, 0, 1, 1, 20'h00000, 20'h12345, 4'h1, 1, 0);
    // memory write, region 1, then relatch to region 0
    step(0, 1, 0, 1, 1, 20'h9ABCD, 20'h9ABCD, 4'h2, 1, 0);
    step(0, 0, 0, 1, 0, 20'h00000, 20'h9ABCD, 4'h2, 1, 0);
    step(0, 0, 0, 1, 1, 20'h00000, 20'h9ABCD, 4'h2, 1, 0);
    step(0, 1, 0, 1, 1, 20'h00010, 20'h00010, 4'h1, 1, 0);
    step(0, 0, 0, 1, 1, 20'h00000, 20'h00010, 4'h1, 1, 0);
    // IO read 0xFF07, 2 wait states
    step(0, 1, 1, 1, 1, 20'h0FF07, 20'h0FF07, 4'h4, 1, 0);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h0FF07, 4'h4, 0, 0);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h0FF07, 4'h4, 0, 0);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h0FF07, 4'h4, 1, 0);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h0FF07, 4'h4, 1, 0);
    step(0, 0, 1, 1, 1, 20'h00000, 20'h0FF07, 4'h4, 1, 0);
    // IO write 0x1DFF, 5 wait states
    step(0, 1, 1, 1, 1, 20'h01DFF, 20'h01DFF, 4'h8, 1, 0);
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 1, 0, 20'h00000, 20'h01DFF, 4'h8, 0, 0);
    step(0, 0, 1, 1, 0, 20'h00000, 20'h01DFF, 4'h8, 1, 0);
    step(0, 0, 1, 1, 1, 20'h00000, 20'h01DFF, 4'h8, 1, 0);
    // IO read 0x3000 hits nothing
    step(0, 1, 1, 1, 1, 20'h03000, 20'h03000, 4'h0, 1, 0);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h03000, 4'h0, 1, 1);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h03000, 4'h0, 1, 0);
    step(0, 0, 1, 1, 1, 20'h00000, 20'h03000, 4'h0, 1, 0);
    // strobe in IDLE is ignored
    step(0, 0, 1, 0, 1, 20'h00000, 20'h03000, 4'h0, 1, 0);
    step(0, 0, 1, 1, 1, 20'h00000, 20'h03000, 4'h0, 1, 0);
    // reset on third READY-low cycle
    step(0, 1, 1, 1, 1, 20'h01C00, 20'h01C00, 4'h8, 1, 0);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h01C00, 4'h8, 0, 0);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h01C00, 4'h8, 0, 0);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h01C00, 4'h8, 0, 0);
    step(1, 0, 1, 0, 1, 20'h00000, 20'h00000, 4'h0, 1, 0);
    step(0, 0, 1, 1, 1, 20'h00000, 20'h00000, 4'h0, 1, 0);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h00000, 4'h0, 1, 0);
    // normal decode after reset, then ALE mid-wait
    step(0, 1, 1, 1, 1, 20'h01C00, 20'h01C00, 4'h8, 1, 0);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h01C00, 4'h8, 0, 0);
    step(0, 0, 1, 0, 1, 20'h00000, 20'h01C00, 4'h8, 0, 0);
    step(0, 1, 0, 1, 1, 20'h00000, 20'h00000, 4'h1, 1, 0);
    step(0, 0, 0, 0, 1, 20'h00000, 20'h00000, 4'h1, 1, 0);
    step(0, 0, 0, 1, 1, 20'h00000, 20'h00000, 4'h1, 1, 0);
    // RESET beats ALE
    step(1, 1, 0, 1, 1, 20'h12345, 20'h00000, 4'h0, 1, 0);
    step(0, 0, 0, 1, 1, 20'h00000, 20'h00000, 4'h0, 1, 0);
    // RD and WR low together behave as one strobe
    step(0, 1, 1, 1, 1, 20'h0FF00, 20'h0FF00, 4'h4, 1, 0);
    step(0, 0, 1, 0, 0, 20'h00000, 20'h0FF00, 4'h4, 0, 0);
    step(0, 0, 1, 0, 0, 20'h00000, 20'h0FF00, 4'h4, 0, 0);
    step(0, 0, 1, 0, 0, 20'h00000, 20'h0FF00, 4'h4, 1, 0);
    step(0, 0, 1, 1, 1, 20'h00000, 20'h0FF00, 4'h4, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
